// File: rtl/ss_division_framed_if.sv
// ---------------------------------------------------------------------------
// ss_division_framed_if
//   Bundles the harness-side signals of the stochastic-symbol divider.
//   master : request side (harness / testbench). It drives start, the
//            operands and the three random words, and receives busy, done
//            and result.
//   slave  : the divider itself.
//   Signals:
//     start                 frame request, honoured only while idle
//     x_input, y_input      dividend / divisor, SW integer + RW fraction bits
//     x/y/z_randnum         uniform random words, fresh every cycle
//     busy                  frame in progress
//     done                  one-cycle pulse, result valid
//     result                sum of quotient symbols over the window
// ---------------------------------------------------------------------------
interface ss_division_framed_if #(
    parameter int SW       = 3,
    parameter int RW       = 8,
    parameter int WIN_LOG2 = 10
);
    logic                   start;
    logic [SW+RW-1:0]       x_input;
    logic [SW+RW-1:0]       y_input;
    logic [RW-1:0]          x_randnum;
    logic [RW-1:0]          y_randnum;
    logic [RW-1:0]          z_randnum;
    logic                   busy;
    logic                   done;
    logic [SW+WIN_LOG2-1:0] result;

    modport master (
        output start, x_input, y_input, x_randnum, y_randnum, z_randnum,
        input  busy, done, result
    );

    modport slave (
        input  start, x_input, y_input, x_randnum, y_randnum, z_randnum,
        output busy, done, result
    );
endinterface

// File: rtl/ss_division_framed.sv
// ---------------------------------------------------------------------------
// ss_division_framed
//   Stochastic-symbol divider with a framed measurement window.
//   Both operands are turned into symbol streams; a feedback integrator (est)
//   settles so that its own symbol stream z_ss tracks M*x/y. After WARMUP
//   settling cycles the z_ss symbols are summed over 2^WIN_LOG2 cycles and the
//   sum is returned as a registered result with a one-cycle done pulse.
//   Ports:
//     clk   clock, all state changes on the rising edge
//     rst   synchronous, active-low reset
//     bus   ss_division_framed_if.slave (start/operands/randoms in,
//           busy/done/result out)
// ---------------------------------------------------------------------------
module ss_division_framed #(
    parameter int SW       = 3,
    parameter int RW       = 8,
    parameter int WIN_LOG2 = 10,
    parameter int WARMUP   = 64
) (
    input  logic                clk,
    input  logic                rst,
    ss_division_framed_if.slave bus
);
    localparam int VW = SW + RW;           // operand / integrator width
    localparam int EW = SW + RW + 2;       // signed update width
    localparam int AW = SW + WIN_LOG2;     // accumulator / result width
    localparam int M  = (1 << SW) - 1;     // full-scale symbol
    localparam int WARM_BITS = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int CW = (WIN_LOG2 > WARM_BITS) ? WIN_LOG2 : WARM_BITS;

    localparam logic [VW-1:0] EST_MAX   = VW'(M << RW);
    localparam logic [CW-1:0] WARM_LAST = CW'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [CW-1:0] RUN_LAST  = CW'((1 << WIN_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic [VW-1:0] est_q, est_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [AW-1:0] result_q, result_d;
    logic          done_q, done_d;

    // Symbol generator: integer part plus one when the fraction beats the
    // random word, so the expected symbol equals the fixed-point value.
    // The integer part is at most M, so only the M+1 case needs saturating.
    function automatic logic [SW-1:0] sym_gen(input logic [VW-1:0] v,
                                              input logic [RW-1:0] r);
        logic [SW:0] s;
        s = {1'b0, v[VW-1:RW]} + (SW+1)'(v[RW-1:0] > r);
        return (s > (SW+1)'(M)) ? SW'(M) : s[SW-1:0];
    endfunction

    logic [SW-1:0] x_ss, y_ss, z_ss;

    assign x_ss = sym_gen(x_q,   bus.x_randnum);
    assign y_ss = sym_gen(y_q,   bus.y_randnum);
    assign z_ss = sym_gen(est_q, bus.z_randnum);

    // Integrator update: est + (x_ss*M - y_ss*z_ss), clamped to [0, M*2^RW].
    // At equilibrium E[y_ss]*E[z_ss] = M*E[x_ss], i.e. z_ss tracks M*x/y.
    logic [2*SW-1:0]      drive_x, drive_yz;
    logic signed [EW-1:0] est_sum;
    logic [VW-1:0]        est_next;

    always_comb begin
        drive_x  = (2*SW)'(x_ss) * (2*SW)'(M);
        drive_yz = (2*SW)'(y_ss) * (2*SW)'(z_ss);
        est_sum  = $signed({2'b00, est_q}) + $signed(EW'(drive_x))
                 - $signed(EW'(drive_yz));
        if (est_sum < 0) begin
            est_next = '0;
        end else if (est_sum > $signed({2'b00, EST_MAX})) begin
            est_next = EST_MAX;
        end else begin
            est_next = est_sum[VW-1:0];
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        est_d    = est_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    x_d     = bus.x_input;
                    y_d     = bus.y_input;
                    est_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = (WARMUP == 0) ? S_RUN : S_WARM;
                end
            end

            S_WARM: begin
                est_d = est_next;
                if (cnt_q == WARM_LAST) begin
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_RUN: begin
                est_d = est_next;
                acc_d = acc_q + AW'(z_ss);
                if (cnt_q == RUN_LAST) begin
                    // Fold the final symbol straight into the result so the
                    // window holds exactly 2^WIN_LOG2 symbols.
                    result_d = acc_q + AW'(z_ss);
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge (synchronous, active-low), and
    // all state uses non-blocking assignments so every register sees the
    // pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            est_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            est_q    <= est_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_ss_division_framed.sv
// ---------------------------------------------------------------------------
// tb_ss_division_framed
//   Self-checking bench for ss_division_framed. Random words for every edge
//   are drawn up front, so a plain arithmetic reference model can replay any
//   frame from its accept edge and predict the exact result.
// ---------------------------------------------------------------------------
module tb_ss_division_framed;
    localparam int SW       = 3;
    localparam int RW       = 8;
    localparam int WIN_LOG2 = 10;
    localparam int WARMUP   = 64;
    localparam int VW       = SW + RW;
    localparam int M        = (1 << SW) - 1;
    localparam int N        = 1 << WIN_LOG2;
    localparam int LAT      = WARMUP + N;
    localparam int FULL     = M * N;
    localparam int MAXE     = 20000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ss_division_framed_if #(.SW(SW), .RW(RW), .WIN_LOG2(WIN_LOG2)) bus ();

    ss_division_framed #(
        .SW(SW), .RW(RW), .WIN_LOG2(WIN_LOG2), .WARMUP(WARMUP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int edge_n = 0;   // index of the next rising edge

    logic [RW-1:0] rx [MAXE];
    logic [RW-1:0] ry [MAXE];
    logic [RW-1:0] rz [MAXE];

    typedef struct {
        string name;
        int    x;
        int    y;
        int    lo;
        int    hi;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input longint act,
                               input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic apply_rand();
        if (edge_n >= MAXE) begin
            $display("FAIL stimulus_budget: got edge %0d expected below %0d", edge_n, MAXE);
            $fatal(1);
        end
        bus.x_randnum = rx[edge_n];
        bus.y_randnum = ry[edge_n];
        bus.z_randnum = rz[edge_n];
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, when the
    // randoms for the following edge are also applied.
    task automatic cycle();
        @(posedge clk);
        #1;
        edge_n++;
        apply_rand();
    endtask

    // Reference model: expected symbol of a fixed-point value.
    function automatic int sym(input int v, input int r);
        int s;
        s = (v >> RW) + (((v % (1 << RW)) > r) ? 1 : 0);
        return (s > M) ? M : s;
    endfunction

    // Replays the frame accepted at edge t_acc: WARMUP settling edges, then N
    // edges whose quotient symbols are summed.
    function automatic int predict(input int x, input int y, input int t_acc);
        int est;
        int total;
        int xs, ys, zs;
        est   = 0;
        total = 0;
        for (int k = t_acc + 1; k <= t_acc + LAT; k++) begin
            xs = sym(x, int'(rx[k]));
            ys = sym(y, int'(ry[k]));
            zs = sym(est, int'(rz[k]));
            if (k > t_acc + WARMUP) total += zs;
            est = est + xs * M - ys * zs;
            if (est < 0) est = 0;
            if (est > (M << RW)) est = M << RW;
        end
        return total;
    endfunction

    task automatic run_frame(input string name, input int x, input int y,
                             input int lo, input int hi);
        int t_acc;
        int n;
        int res;
        bit seen;
        bus.x_input = VW'(x);
        bus.y_input = VW'(y);
        bus.start   = 1'b1;
        t_acc       = edge_n;
        cycle();
        bus.start   = 1'b0;
        // Operand changes after accept must not disturb the frame.
        bus.x_input = VW'($urandom);
        bus.y_input = VW'($urandom);
        check({name, "_busy_after_accept"}, bus.busy, 1);
        n    = 1;
        seen = 1'b0;
        while (!seen && n <= LAT + 50) begin
            if (bus.done) begin
                seen = 1'b1;
            end else begin
                cycle();
                n++;
            end
        end
        if (seen) begin
            res = predict(x, y, t_acc);
            check({name, "_latency"}, n - 1, LAT);
            check({name, "_busy_in_done"}, bus.busy, 0);
            check({name, "_result"}, bus.result, res);
            check_range({name, "_result_range"}, bus.result, lo, hi);
            cycle();
            check({name, "_done_one_cycle"}, bus.done, 0);
            check({name, "_result_held"}, bus.result, res);
        end else begin
            check({name, "_done_timeout"}, 0, 1);
        end
    endtask

    initial begin
        int t_acc;
        int n;
        int dones;
        int done_at;
        int res;
        int frames;
        int busy_bad;
        int guard;

        for (int k = 0; k < MAXE; k++) begin
            rx[k] = RW'($urandom);
            ry[k] = RW'($urandom);
            rz[k] = RW'($urandom);
        end

        // ---------------- reset state ----------------
        rst         = 1'b0;
        bus.start   = 1'b1;   // reset must dominate start
        bus.x_input = VW'('h700);
        bus.y_input = VW'('h100);
        apply_rand();
        repeat (3) cycle();
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_result", bus.result, 0);
        bus.start = 1'b0;
        rst       = 1'b1;
        cycle();
        check("idle_busy", bus.busy, 0);

        // ---------------- table-driven frames ----------------
        vecs[0] = '{"zero_dividend", 'h000, 'h700, 0, 0};
        vecs[1] = '{"full_scale",    'h700, 'h700, FULL * 95 / 100, FULL};
        vecs[2] = '{"zero_divisor",  'h700, 'h000, FULL, FULL};
        vecs[3] = '{"random_a", int'($urandom_range(0, 'h7ff)), int'($urandom_range(0, 'h7ff)), 0, FULL};
        vecs[4] = '{"random_b", int'($urandom_range(0, 'h7ff)), int'($urandom_range(0, 'h7ff)), 0, FULL};
        vecs[5] = '{"ratio_half",    'h200, 'h400, FULL / 2 * 95 / 100, FULL / 2 * 105 / 100};
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].lo, vecs[i].hi);
        end

        // ---------------- reset in the middle of RUN ----------------
        bus.x_input = VW'('h700);
        bus.y_input = VW'('h380);
        bus.start   = 1'b1;
        cycle();
        bus.start   = 1'b0;
        repeat (WARMUP + 200) cycle();
        check("midrun_busy_before_reset", bus.busy, 1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check("midrun_reset_busy", bus.busy, 0);
        check("midrun_reset_done", bus.done, 0);
        check("midrun_reset_result", bus.result, 0);
        dones = 0;
        for (int c = 0; c < LAT + 20; c++) begin
            if (bus.done) dones++;
            cycle();
        end
        check("midrun_no_done_after_abandon", dones, 0);
        run_frame("after_reset", 'h300, 'h600, FULL / 2 * 95 / 100, FULL / 2 * 105 / 100);

        // ---------------- start pulses while busy ----------------
        bus.x_input = VW'('h200);
        bus.y_input = VW'('h400);
        bus.start   = 1'b1;
        t_acc       = edge_n;
        cycle();
        bus.start   = 1'b0;
        dones   = 0;
        done_at = 0;
        res     = 0;
        for (int c = 1; c <= LAT + 100; c++) begin
            if (bus.done) begin
                dones++;
                done_at = c;
                res     = int'(bus.result);
            end
            // Pulses land mid-WARM, mid-RUN and on the final RUN edge.
            if (c == 10 || c == 500 || c == LAT) begin
                bus.start   = 1'b1;
                bus.x_input = VW'('h700);
            end else begin
                bus.start = 1'b0;
            end
            cycle();
        end
        check("ignore_start_done_count", dones, 1);
        check("ignore_start_done_edge", done_at, LAT + 1);
        check("ignore_start_result", res, predict('h200, 'h400, t_acc));
        check("ignore_start_idle_after", bus.busy, 0);

        // ---------------- start held high: back-to-back frames ----------------
        bus.x_input = VW'('h300);
        bus.y_input = VW'('h600);
        bus.start   = 1'b1;
        t_acc    = edge_n;
        cycle();
        n        = 1;
        frames   = 0;
        busy_bad = 0;
        guard    = 0;
        while (frames < 3 && guard < 4 * (LAT + 1)) begin
            if (bus.done) begin
                check($sformatf("b2b_period_%0d", frames), n, LAT + 1);
                check($sformatf("b2b_busy_in_done_%0d", frames), bus.busy, 0);
                check($sformatf("b2b_result_%0d", frames), bus.result,
                      predict('h300, 'h600, t_acc));
                frames++;
                t_acc = edge_n;
                n     = 0;
            end else if (!bus.busy) begin
                busy_bad++;
            end
            cycle();
            n++;
            guard++;
        end
        bus.start = 1'b0;
        check("b2b_frames", frames, 3);
        check("b2b_busy_low_outside_done", busy_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

endmodule
